mem_stage: RTL and testbench

- Memory-access stage directly downstream of the execute stage.
- Takes the execute result (ALU result, store data, destination, control) through a valid/ready handshake and issues loads/stores on the data bus.
- Waits for the bus response, then presents the writeback record to the writeback stage.
- Holds one instruction at a time; stalls upstream while a bus transaction is outstanding.

---
 rtl/mem_stage_if.sv | 63 ++++++
 rtl/mem_stage.sv | 144 ++++++++++++++
 tb/tb_mem_stage.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-side handshake, data-bus request/response and
// writeback-side signals of the memory stage, bundled into one interface.
// With MEM_LOAD_EXT_EN defined the bundle also carries in_unsigned.
interface mem_stage_if #(
  parameter int XLEN    = 64,
  parameter int REGADDR = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_result;
  logic [XLEN-1:0]    in_wdata;
  logic               in_memread;
  logic               in_memwrite;
  logic [1:0]         in_msize;
  logic [REGADDR-1:0] in_dst;
  logic               in_regwrite;
`ifdef MEM_LOAD_EXT_EN
  logic               in_unsigned;
`endif

  logic               dreq_valid;
  logic [XLEN-1:0]    dreq_addr;
  logic [1:0]         dreq_size;
  logic [7:0]         dreq_strobe;
  logic [XLEN-1:0]    dreq_data;
  logic               dresp_data_ok;
  logic [XLEN-1:0]    dresp_data;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [REGADDR-1:0] out_dst;
  logic               out_regwrite;
  logic               out_misalign;

  // Stage side.
  modport slave (
`ifdef MEM_LOAD_EXT_EN
    input  in_unsigned,
`endif
    input  in_valid, output in_ready, input in_result, input in_wdata,
    input  in_memread, input in_memwrite, input in_msize, input in_dst,
    input  in_regwrite,
    output dreq_valid, output dreq_addr, output dreq_size, output dreq_strobe,
    output dreq_data, input dresp_data_ok, input dresp_data,
    output out_valid, input out_ready, output out_result, output out_dst,
    output out_regwrite, output out_misalign
  );

  // Environment side: execute stage, data bus and writeback stage.
  modport master (
`ifdef MEM_LOAD_EXT_EN
    output in_unsigned,
`endif
    output in_valid, input in_ready, output in_result, output in_wdata,
    output in_memread, output in_memwrite, output in_msize, output in_dst,
    output in_regwrite,
    input  dreq_valid, input dreq_addr, input dreq_size, input dreq_strobe,
    input  dreq_data, output dresp_data_ok, output dresp_data,
    input  out_valid, output out_ready, input out_result, input out_dst,
    input  out_regwrite, input out_misalign
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback. Holds one
// instruction, issues a single load/store on the data bus and presents the
// writeback record once the bus answers.
// Optional feature macro MEM_LOAD_EXT_EN: loads extract the addressed lane
// and sign-extend (or zero-extend with in_unsigned) to XLEN.
//
// state | meaning
// IDLE  | in_ready=1, waiting for an execute record
// BUS   | request on the data bus, waiting for dresp_data_ok
// DONE  | writeback record valid, waiting for out_ready
module mem_stage #(
  parameter int XLEN    = 64,
  parameter int REGADDR = 5
) (
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave io
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} stateT;

  stateT              state;
  logic               isLoad;
  logic [REGADDR-1:0] dstQ;
  logic               regwriteQ;
`ifdef MEM_LOAD_EXT_EN
  logic               unsignedQ;
  logic [XLEN-1:0]    lane;
`endif

  logic               isMem;
  logic               misaligned;
  logic [2:0]         alignMask;
  logic [7:0]         laneMask;
  logic [7:0]         storeStrobe;
  logic [XLEN-1:0]    storeData;
  logic [XLEN-1:0]    loadValue;

  // Decode the incoming record: alignment, byte lanes and aligned store data.
  always_comb begin
    isMem = io.in_memread || io.in_memwrite;
    case (io.in_msize)
      2'd0:    begin laneMask = 8'h01; alignMask = 3'b000; end
      2'd1:    begin laneMask = 8'h03; alignMask = 3'b001; end
      2'd2:    begin laneMask = 8'h0F; alignMask = 3'b011; end
      default: begin laneMask = 8'hFF; alignMask = 3'b111; end
    endcase
    misaligned  = isMem && ((io.in_result[2:0] & alignMask) != 3'b000);
    storeStrobe = laneMask << io.in_result[2:0];
    storeData   = io.in_wdata << {io.in_result[2:0], 3'b000};
  end

  // Shape the returned load data; request address/size are still held here.
  always_comb begin
`ifdef MEM_LOAD_EXT_EN
    lane = io.dresp_data >> {io.dreq_addr[2:0], 3'b000};
    case (io.dreq_size)
      2'd0:    loadValue = {{(XLEN-8){lane[7] & ~unsignedQ}}, lane[7:0]};
      2'd1:    loadValue = {{(XLEN-16){lane[15] & ~unsignedQ}}, lane[15:0]};
      2'd2:    loadValue = {{(XLEN-32){lane[31] & ~unsignedQ}}, lane[31:0]};
      default: loadValue = lane;
    endcase
`else
    loadValue = io.dresp_data;
`endif
  end

  // Stage FSM with registered handshake, bus and writeback outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      isLoad          <= 1'b0;
      dstQ            <= '0;
      regwriteQ       <= 1'b0;
`ifdef MEM_LOAD_EXT_EN
      unsignedQ       <= 1'b0;
`endif
      io.in_ready     <= 1'b1;
      io.dreq_valid   <= 1'b0;
      io.dreq_addr    <= '0;
      io.dreq_size    <= 2'd0;
      io.dreq_strobe  <= 8'h00;
      io.dreq_data    <= '0;
      io.out_valid    <= 1'b0;
      io.out_result   <= '0;
      io.out_dst      <= '0;
      io.out_regwrite <= 1'b0;
      io.out_misalign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            io.in_ready <= 1'b0;
            // Both memread and memwrite set is treated as a store.
            isLoad      <= io.in_memread && !io.in_memwrite;
            dstQ        <= io.in_dst;
            regwriteQ   <= io.in_regwrite;
`ifdef MEM_LOAD_EXT_EN
            unsignedQ   <= io.in_unsigned;
`endif
            if (!isMem || misaligned) begin
              io.out_valid    <= 1'b1;
              io.out_result   <= io.in_result;
              io.out_dst      <= io.in_dst;
              io.out_regwrite <= io.in_regwrite && !misaligned;
              io.out_misalign <= misaligned;
              state           <= DONE;
            end else begin
              io.dreq_valid  <= 1'b1;
              io.dreq_addr   <= io.in_result;
              io.dreq_size   <= io.in_msize;
              io.dreq_strobe <= io.in_memwrite ? storeStrobe : 8'h00;
              io.dreq_data   <= io.in_memwrite ? storeData : '0;
              state          <= BUS;
            end
          end
        end
        BUS: begin
          if (io.dresp_data_ok) begin
            io.dreq_valid   <= 1'b0;
            io.dreq_strobe  <= 8'h00;
            io.dreq_data    <= '0;
            // dreq_addr still holds the ALU result for the store passthrough.
            io.out_result   <= isLoad ? loadValue : io.dreq_addr;
            io.out_valid    <= 1'b1;
            io.out_dst      <= dstQ;
            io.out_regwrite <= regwriteQ;
            io.out_misalign <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            io.in_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed bench for mem_stage with a
// byte-level reference model of strobes, store lanes and load extension.
module tb_mem_stage;
  localparam int XLEN    = 64;
  localparam int REGADDR = 5;
`ifdef MEM_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  mem_stage_if #(.XLEN(XLEN), .REGADDR(REGADDR)) io ();
  mem_stage #(.XLEN(XLEN), .REGADDR(REGADDR)) dut (.clk(clk), .reset(reset), .io(io));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    io.in_valid      = 1'b0;
    io.in_result     = '0;
    io.in_wdata      = '0;
    io.in_memread    = 1'b0;
    io.in_memwrite   = 1'b0;
    io.in_msize      = 2'd0;
    io.in_dst        = '0;
    io.in_regwrite   = 1'b0;
`ifdef MEM_LOAD_EXT_EN
    io.in_unsigned   = 1'b0;
`endif
    io.dresp_data_ok = 1'b0;
    io.dresp_data    = '0;
    io.out_ready     = 1'b0;
  endtask

  task automatic present(input logic [63:0] addr, input logic [63:0] wdata,
                         input logic rd, input logic wr, input logic [1:0] size,
                         input logic [4:0] dst, input logic rw);
    io.in_valid    = 1'b1;
    io.in_result   = addr;
    io.in_wdata    = wdata;
    io.in_memread  = rd;
    io.in_memwrite = wr;
    io.in_msize    = size;
    io.in_dst      = dst;
    io.in_regwrite = rw;
  endtask

  // Reference: every byte of the access enables its own lane.
  function automatic logic [7:0] expStrobe(input logic [2:0] off, input int size);
    logic [7:0] s = 8'h00;
    int o = int'(off);
    for (int i = 0; i < (1 << size); i++) s[o + i] = 1'b1;
    return s;
  endfunction

  // Reference: byte k of wdata lands in lane off+k.
  function automatic logic [63:0] expData(input logic [63:0] wdata, input logic [2:0] off);
    logic [63:0] d = '0;
    int o = int'(off);
    for (int j = o; j < 8; j++) d[8*j +: 8] = wdata[8*(j-o) +: 8];
    return d;
  endfunction

  // Reference: gather the accessed bytes, then extend from the top byte.
  function automatic logic [63:0] expLoad(input logic [63:0] raw, input logic [2:0] off,
                                          input int size, input logic uns);
    logic [63:0] v = '0;
    int nb = 1 << size;
    int o = int'(off);
    if (!EXT) return raw;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(o+i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1]) v = v | (~64'd0 << (8*nb));
    return v;
  endfunction

  task automatic test_reset();
    idleInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if (io.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", io.in_ready); end
    tests++; if (io.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", io.out_valid); end
    tests++; if (io.dreq_valid !== 1'b0) begin fails++; $display("FAIL reset_dreq_valid got %0b want 0", io.dreq_valid); end
    tests++; if (io.out_misalign !== 1'b0 || io.out_regwrite !== 1'b0) begin fails++; $display("FAIL reset_flags got mis=%0b rw=%0b want 0 0", io.out_misalign, io.out_regwrite); end
    tests++; if (io.out_result !== 64'd0 || io.dreq_strobe !== 8'h00) begin fails++; $display("FAIL reset_values got res=%h strobe=%h want 0 0", io.out_result, io.dreq_strobe); end
  endtask

  task automatic test_passthrough();
    present(64'h1234, 64'h0, 1'b0, 1'b0, 2'd3, 5'd5, 1'b1);
    tick();
    io.in_valid = 1'b0;
    tests++; if (io.out_valid !== 1'b1 || io.dreq_valid !== 1'b0) begin fails++; $display("FAIL pass_valid got out=%0b dreq=%0b want 1 0", io.out_valid, io.dreq_valid); end
    tests++; if (io.out_result !== 64'h1234 || io.out_dst !== 5'd5 || io.out_regwrite !== 1'b1) begin fails++; $display("FAIL pass_record got %h/%0d/%0b want 1234/5/1", io.out_result, io.out_dst, io.out_regwrite); end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    tests++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin fails++; $display("FAIL pass_release got out=%0b rdy=%0b want 0 1", io.out_valid, io.in_ready); end
  endtask

  task automatic test_load_double();
    int held = 0;
    present(64'h80000008, 64'h0, 1'b1, 1'b0, 2'd3, 5'd7, 1'b1);
    tick();
    io.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (io.dreq_valid === 1'b1 && io.in_ready === 1'b0 && io.dreq_addr === 64'h80000008
          && io.dreq_size === 2'd3 && io.dreq_strobe === 8'h00) held++;
      if (c == 2) begin
        io.dresp_data_ok = 1'b1;
        io.dresp_data    = 64'hDEADBEEF_CAFEF00D;
      end
      tick();
    end
    io.dresp_data_ok = 1'b0;
    tests++; if (held !== 3) begin fails++; $display("FAIL ld_held got %0d want 3 cycles", held); end
    tests++; if (io.out_valid !== 1'b1 || io.dreq_valid !== 1'b0) begin fails++; $display("FAIL ld_done got out=%0b dreq=%0b want 1 0", io.out_valid, io.dreq_valid); end
    tests++; if (io.out_result !== 64'hDEADBEEF_CAFEF00D || io.out_dst !== 5'd7) begin fails++; $display("FAIL ld_result got %h/%0d want deadbeefcafef00d/7", io.out_result, io.out_dst); end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  task automatic test_store_byte();
    present(64'h80000003, 64'hAB, 1'b0, 1'b1, 2'd0, 5'd9, 1'b0);
    tick();
    io.in_valid = 1'b0;
    tests++; if (io.dreq_valid !== 1'b1 || io.dreq_strobe !== 8'h08) begin fails++; $display("FAIL st_strobe got v=%0b s=%h want 1 08", io.dreq_valid, io.dreq_strobe); end
    tests++; if (io.dreq_data !== 64'hAB000000) begin fails++; $display("FAIL st_data got %h want ab000000", io.dreq_data); end
    io.dresp_data_ok = 1'b1;
    tick();
    io.dresp_data_ok = 1'b0;
    tests++; if (io.out_valid !== 1'b1 || io.out_regwrite !== 1'b0 || io.out_result !== 64'h80000003) begin fails++; $display("FAIL st_done got v=%0b rw=%0b res=%h want 1 0 80000003", io.out_valid, io.out_regwrite, io.out_result); end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    int sawReq = 0;
    present(64'h80000002, 64'h0, 1'b1, 1'b0, 2'd2, 5'd3, 1'b1);
    if (io.dreq_valid === 1'b1) sawReq++;
    tick();
    io.in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (io.dreq_valid === 1'b1) sawReq++;
      tick();
    end
    tests++; if (sawReq !== 0) begin fails++; $display("FAIL mis_noreq got %0d req cycles want 0", sawReq); end
    tests++; if (io.out_valid !== 1'b1 || io.out_misalign !== 1'b1 || io.out_regwrite !== 1'b0) begin fails++; $display("FAIL mis_flags got v=%0b mis=%0b rw=%0b want 1 1 0", io.out_valid, io.out_misalign, io.out_regwrite); end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    int stable = 0;
    present(64'h5555, 64'h0, 1'b0, 1'b0, 2'd0, 5'd2, 1'b1);
    tick();
    io.in_result = 64'h9999;
    io.in_dst    = 5'd30;
    for (int c = 0; c < 5; c++) begin
      if (io.out_valid === 1'b1 && io.out_result === 64'h5555 && io.out_dst === 5'd2 && io.in_ready === 1'b0) stable++;
      tick();
    end
    io.in_valid = 1'b0;
    tests++; if (stable !== 5) begin fails++; $display("FAIL bp_stable got %0d want 5 cycles", stable); end
    io.out_ready = 1'b1;
    tick();
    io.out_ready = 1'b0;
    present(64'h100, 64'h0, 1'b1, 1'b0, 2'd3, 5'd1, 1'b1);
    tick();
    io.in_valid = 1'b0;
    tests++; if (io.dreq_valid !== 1'b1) begin fails++; $display("FAIL rst_inbus got dreq=%0b want 1", io.dreq_valid); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (io.dreq_valid !== 1'b0 || io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin fails++; $display("FAIL rst_bus got dreq=%0b out=%0b rdy=%0b want 0 0 1", io.dreq_valid, io.out_valid, io.in_ready); end
    io.dresp_data_ok = 1'b1;
    io.dresp_data    = 64'h77;
    tick();
    io.dresp_data_ok = 1'b0;
    tick();
    tests++; if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1 || io.dreq_valid !== 1'b0) begin fails++; $display("FAIL rst_late got out=%0b rdy=%0b dreq=%0b want 0 1 0", io.out_valid, io.in_ready, io.dreq_valid); end
  endtask

`ifdef MEM_LOAD_EXT_EN
  task automatic test_load_ext();
    logic [63:0] want;
    for (int u = 0; u < 2; u++) begin
      present(64'h80000001, 64'h0, 1'b1, 1'b0, 2'd0, 5'd4, 1'b1);
      io.in_unsigned = (u == 1);
      want = (u == 1) ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80;
      tick();
      io.in_valid      = 1'b0;
      io.dresp_data_ok = 1'b1;
      io.dresp_data    = 64'h0000_0000_0000_8000;
      tick();
      io.dresp_data_ok = 1'b0;
      io.in_unsigned   = 1'b0;
      tests++; if (io.out_valid !== 1'b1 || io.out_result !== want) begin fails++; $display("FAIL ext_byte uns=%0d got %h want %h", u, io.out_result, want); end
      io.out_ready = 1'b1;
      tick();
      io.out_ready = 1'b0;
    end
  endtask
`endif

  task automatic test_random();
    logic [63:0] addr, wdata, rdata, want;
    logic [1:0]  size;
    logic [4:0]  dst;
    logic        rd, wr, rw, uns, mem, mis;
    int kind, lat, bp;
    for (int n = 0; n < 150; n++) begin
      kind  = $urandom_range(0, 3);
      size  = 2'($urandom_range(0, 3));
      rd    = (kind == 1 || kind == 3);
      wr    = (kind == 2 || kind == 3);
      mem   = rd || wr;
      addr  = {$urandom(), $urandom()} & ~((64'd1 << size) - 64'd1);
      if (mem && size != 2'd0 && $urandom_range(0, 4) == 0)
        addr = addr | 64'($urandom_range(1, (1 << size) - 1));
      mis   = mem && ((addr % (64'd1 << size)) != 64'd0);
      wdata = {$urandom(), $urandom()};
      rdata = {$urandom(), $urandom()};
      dst   = 5'($urandom_range(0, 31));
      rw    = 1'($urandom_range(0, 1));
      uns   = EXT ? 1'($urandom_range(0, 1)) : 1'b0;
      lat   = $urandom_range(0, 3);
      bp    = $urandom_range(0, 2);
      present(addr, wdata, rd, wr, size, dst, rw);
`ifdef MEM_LOAD_EXT_EN
      io.in_unsigned = uns;
`endif
      tick();
      io.in_valid = 1'b0;
      if (!mem || mis) begin
        tests++;
        if (io.dreq_valid !== 1'b0 || io.out_valid !== 1'b1 || io.out_misalign !== mis
            || io.out_regwrite !== (rw && !mis) || io.out_dst !== dst
            || (!mis && io.out_result !== addr)) begin
          fails++;
          $display("FAIL rnd_direct n=%0d got dreq=%0b v=%0b mis=%0b rw=%0b dst=%0d res=%h want 0 1 %0b %0b %0d %h",
                   n, io.dreq_valid, io.out_valid, io.out_misalign, io.out_regwrite, io.out_dst, io.out_result,
                   mis, rw && !mis, dst, addr);
        end
      end else begin
        want = wr ? expStrobe(addr[2:0], int'(size)) : 8'h00;
        tests++;
        if (io.dreq_valid !== 1'b1 || io.in_ready !== 1'b0 || io.dreq_addr !== addr
            || io.dreq_size !== size || io.dreq_strobe !== want[7:0]
            || (wr && io.dreq_data !== expData(wdata, addr[2:0]))) begin
          fails++;
          $display("FAIL rnd_req n=%0d got v=%0b a=%h sz=%0d s=%h d=%h want 1 %h %0d %h %h",
                   n, io.dreq_valid, io.dreq_addr, io.dreq_size, io.dreq_strobe, io.dreq_data,
                   addr, size, want[7:0], expData(wdata, addr[2:0]));
        end
        for (int c = 0; c < lat; c++) begin
          tick();
          tests++;
          if (io.dreq_valid !== 1'b1 || io.dreq_addr !== addr || io.dreq_strobe !== want[7:0] || io.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rnd_hold n=%0d c=%0d got v=%0b a=%h s=%h out=%0b", n, c, io.dreq_valid, io.dreq_addr, io.dreq_strobe, io.out_valid);
          end
        end
        io.dresp_data_ok = 1'b1;
        io.dresp_data    = rdata;
        tick();
        io.dresp_data_ok = 1'b0;
        want = (rd && !wr) ? expLoad(rdata, addr[2:0], int'(size), uns) : addr;
        tests++;
        if (io.out_valid !== 1'b1 || io.dreq_valid !== 1'b0 || io.out_result !== want
            || io.out_regwrite !== rw || io.out_dst !== dst || io.out_misalign !== 1'b0) begin
          fails++;
          $display("FAIL rnd_resp n=%0d got v=%0b dreq=%0b res=%h rw=%0b dst=%0d mis=%0b want 1 0 %h %0b %0d 0",
                   n, io.out_valid, io.dreq_valid, io.out_result, io.out_regwrite, io.out_dst, io.out_misalign,
                   want, rw, dst);
        end
      end
      want = io.out_result;
      for (int c = 0; c < bp; c++) begin
        tick();
        tests++;
        if (io.out_valid !== 1'b1 || io.in_ready !== 1'b0 || io.out_result !== want) begin
          fails++;
          $display("FAIL rnd_bp n=%0d got v=%0b rdy=%0b res=%h", n, io.out_valid, io.in_ready, io.out_result);
        end
      end
      io.out_ready = 1'b1;
      tick();
      io.out_ready = 1'b0;
      tests++;
      if (io.out_valid !== 1'b0 || io.in_ready !== 1'b1) begin
        fails++;
        $display("FAIL rnd_release n=%0d got v=%0b rdy=%0b want 0 1", n, io.out_valid, io.in_ready);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_passthrough();
    test_load_double();
    test_store_byte();
    test_misaligned();
    test_backpressure_reset();
`ifdef MEM_LOAD_EXT_EN
    test_load_ext();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
